siso_alpha_lifo: RTL and testbench



---
 rtl/siso_pkg.sv | 57 +++++
 rtl/alpha_acs.sv | 60 ++++++
 rtl/siso_alpha_lifo.sv | 143 ++++++++++++++
 tb/tb_siso_alpha_lifo.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/siso_pkg.sv
// rtl/siso_pkg.sv - shared types, trellis tables and saturating metric helpers for the SISO alpha engine
//
// Contents:
//   fsm_state_t      block state encoding as seen on fsm_state (0=IDLE, 1=FWD, 2=DRAIN)
//   NEXT_STATE/PARITY 8x2 trellis tables indexed [state][u]
//   sat_t            wide signed scratch type used for metric arithmetic
//   metric_max/metric_neg_inf, sat_add/sat_sub  saturate to an mw-bit signed range
package siso_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FWD   = 2'd1,
        ST_DRAIN = 2'd2
    } fsm_state_t;

    // Wide enough that the sum of two in-range metrics never wraps before clamping.
    localparam int SAT_W = 32;
    typedef logic signed [SAT_W-1:0] sat_t;

    // State {s1,s2,s3}: a = u^s2^s3, z = a^s1^s3, next = {a,s1,s2}.
    localparam logic [2:0] NEXT_STATE [8][2] = '{
        '{3'd0, 3'd4}, '{3'd4, 3'd0}, '{3'd5, 3'd1}, '{3'd1, 3'd5},
        '{3'd2, 3'd6}, '{3'd6, 3'd2}, '{3'd7, 3'd3}, '{3'd3, 3'd7}
    };
    localparam logic PARITY [8][2] = '{
        '{1'b0, 1'b1}, '{1'b0, 1'b1}, '{1'b1, 1'b0}, '{1'b1, 1'b0},
        '{1'b1, 1'b0}, '{1'b1, 1'b0}, '{1'b0, 1'b1}, '{1'b0, 1'b1}
    };

    function automatic sat_t metric_max(input int mw);
        return (sat_t'(1) <<< (mw - 1)) - sat_t'(1);
    endfunction

    // Negative infinity of the metric domain: the most negative mw-bit value.
    function automatic sat_t metric_neg_inf(input int mw);
        return -(sat_t'(1) <<< (mw - 1));
    endfunction

    function automatic sat_t sat_clamp(input sat_t v, input int mw);
        if (v > metric_max(mw)) begin
            return metric_max(mw);
        end
        if (v < metric_neg_inf(mw)) begin
            return metric_neg_inf(mw);
        end
        return v;
    endfunction

    function automatic sat_t sat_add(input sat_t a, input sat_t b, input int mw);
        return sat_clamp(a + b, mw);
    endfunction

    function automatic sat_t sat_sub(input sat_t a, input sat_t b, input int mw);
        return sat_clamp(a - b, mw);
    endfunction

endpackage

// File: rtl/alpha_acs.sv
// rtl/alpha_acs.sv - combinational 8-state add-compare-select for the alpha forward recursion
//
// Ports:
//   br1, br2   in  BW     signed gammas for (u=1,z=1) and (u=1,z=0)
//   alpha_in   in  8*MW   alpha_k, state s at [s*MW +: MW]
//   alpha_nxt  out 8*MW   alpha_{k+1}, same packing
// Macro ALPHA_NORM_EN: when defined, the new state-0 metric is subtracted from all
// eight metrics so state 0 always reads zero.
module alpha_acs
    import siso_pkg::*;
#(
    parameter int BW = 16,
    parameter int MW = 16
) (
    input  logic signed [BW-1:0]   br1,
    input  logic signed [BW-1:0]   br2,
    input  logic        [8*MW-1:0] alpha_in,
    output logic        [8*MW-1:0] alpha_nxt
);

    sat_t w_gamma [4];
    sat_t w_best  [8];
    sat_t w_cand;
`ifdef ALPHA_NORM_EN
    sat_t w_ref;
`endif

    always_comb begin
        // Gamma table indexed by {u,z}; the u=0 branches are the negated u=1 ones.
        w_gamma[0] = -sat_t'(br1);
        w_gamma[1] = -sat_t'(br2);
        w_gamma[2] =  sat_t'(br2);
        w_gamma[3] =  sat_t'(br1);
        w_cand     = '0;
        for (int ns = 0; ns < 8; ns++) begin
            w_best[ns] = metric_neg_inf(MW);
        end
        // Each state fans out to two successors; keep the larger arrival per successor.
        for (int s = 0; s < 8; s++) begin
            for (int u = 0; u < 2; u++) begin
                w_cand = sat_add(sat_t'($signed(alpha_in[s*MW +: MW])),
                                 w_gamma[2*u + (PARITY[s][u] ? 1 : 0)], MW);
                if (w_cand > w_best[NEXT_STATE[s][u]]) begin
                    w_best[NEXT_STATE[s][u]] = w_cand;
                end
            end
        end
`ifdef ALPHA_NORM_EN
        w_ref = w_best[0];
        for (int ns = 0; ns < 8; ns++) begin
            w_best[ns] = sat_sub(w_best[ns], w_ref, MW);
        end
`endif
        alpha_nxt = '0;
        for (int ns = 0; ns < 8; ns++) begin
            alpha_nxt[ns*MW +: MW] = MW'(w_best[ns]);
        end
    end

endmodule

// File: rtl/siso_alpha_lifo.sv
// rtl/siso_alpha_lifo.sv - alpha forward recursion with LIFO replay for the 8-state max-log-MAP SISO
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   blklen, valid_blklen     frame length N (1..MAX_LEN) and its strobe, taken in IDLE
//   init_branch1/2, valid_branch  branch-metric pair per trellis step, taken in FWD
//   alpha_out, valid_alpha, alpha_ready, alpha_last  reverse-order alpha stream, alpha_last on alpha_0
//   fsm_state, ready, len_err     state (0 IDLE/1 FWD/2 DRAIN), idle flag, illegal-length pulse
// Macro ALPHA_NORM_EN selects state-0 normalisation inside alpha_acs.
module siso_alpha_lifo
    import siso_pkg::*;
#(
    parameter int BW      = 16,
    parameter int MW      = 16,
    parameter int MAX_LEN = 6144
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [15:0]          blklen,
    input  logic                 valid_blklen,
    input  logic signed [BW-1:0] init_branch1,
    input  logic signed [BW-1:0] init_branch2,
    input  logic                 valid_branch,
    output logic [8*MW-1:0]      alpha_out,
    output logic                 valid_alpha,
    input  logic                 alpha_ready,
    output logic                 alpha_last,
    output logic [1:0]           fsm_state,
    output logic                 ready,
    output logic                 len_err
);

    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    fsm_state_t        r_state, w_state_nxt;
    logic [15:0]       r_len, r_cnt;
    logic [8*MW-1:0]   r_alpha, w_alpha_nxt, w_alpha0, r_rd_data;
    logic [AW-1:0]     r_rd_addr, w_ram_addr;
    logic              r_rd_pending, r_valid, r_last, r_len_err;
    logic [8*MW-1:0]   r_mem [MAX_LEN];
    logic              w_len_ok, w_start, w_acc, w_acc_last, w_hs, w_load;

    alpha_acs #(.BW(BW), .MW(MW)) u_acs (
        .br1       (init_branch1),
        .br2       (init_branch2),
        .alpha_in  (r_alpha),
        .alpha_nxt (w_alpha_nxt)
    );

    always_comb begin
        w_alpha0 = '0;
        for (int s = 1; s < 8; s++) begin
            w_alpha0[s*MW +: MW] = MW'(metric_neg_inf(MW));
        end
    end

    assign w_len_ok   = (blklen != 16'd0) && ({16'd0, blklen} <= 32'(MAX_LEN));
    assign w_start    = (r_state == ST_IDLE) && valid_blklen && w_len_ok;
    assign w_acc      = (r_state == ST_FWD) && valid_branch;
    assign w_acc_last = w_acc && (r_cnt == r_len - 16'd1);
    assign w_hs       = r_valid && alpha_ready;
    // Refill the output word whenever it is empty or leaving this cycle, so a
    // continuously-ready consumer sees one word per clock.
    assign w_load     = (r_state == ST_DRAIN) && r_rd_pending && (!r_valid || alpha_ready);
    // Writes and reads never overlap, so one address port serves both phases.
    assign w_ram_addr = (r_state == ST_FWD) ? r_cnt[AW-1:0] : r_rd_addr;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_start)          w_state_nxt = ST_FWD;
            ST_FWD:   if (w_acc_last)       w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_hs && r_last)   w_state_nxt = ST_IDLE;
            default:                        w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // LIFO storage; the read register doubles as the output data register.
    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_mem[w_ram_addr] <= r_alpha;
        end
        if (w_load) begin
            r_rd_data <= r_mem[w_ram_addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len        <= '0;
            r_cnt        <= '0;
            r_alpha      <= '0;
            r_rd_addr    <= '0;
            r_rd_pending <= 1'b0;
            r_valid      <= 1'b0;
            r_last       <= 1'b0;
            r_len_err    <= 1'b0;
        end else begin
            r_len_err <= (r_state == ST_IDLE) && valid_blklen && !w_len_ok;
            if (w_start) begin
                r_len   <= blklen;
                r_cnt   <= '0;
                r_alpha <= w_alpha0;
            end
            if (w_acc) begin
                r_alpha <= w_alpha_nxt;
                r_cnt   <= r_cnt + 16'd1;
                if (w_acc_last) begin
                    r_rd_addr    <= r_cnt[AW-1:0];
                    r_rd_pending <= 1'b1;
                end
            end
            if (w_load) begin
                r_valid   <= 1'b1;
                r_last    <= (r_rd_addr == '0);
                r_rd_addr <= r_rd_addr - AW'(1);
                if (r_rd_addr == '0) begin
                    r_rd_pending <= 1'b0;
                end
            end else if (w_hs) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end
        end
    end

    // Masking keeps alpha_out at zero out of reset without resetting the RAM register.
    assign alpha_out   = r_valid ? r_rd_data : '0;
    assign valid_alpha = r_valid;
    assign alpha_last  = r_last;
    assign fsm_state   = r_state;
    assign ready       = (r_state == ST_IDLE);
    assign len_err     = r_len_err;

endmodule

// File: tb/tb_siso_alpha_lifo.sv
// tb/tb_siso_alpha_lifo.sv - self-checking bench for siso_alpha_lifo (BW=8, MW=10, MAX_LEN=16)
module tb_siso_alpha_lifo;

    localparam int BW = 8;
    localparam int MW = 10;
    localparam int ML = 16;
`ifdef ALPHA_NORM_EN
    localparam bit NORM = 1'b1;
`else
    localparam bit NORM = 1'b0;
`endif

    logic                 clk;
    logic                 rst;
    logic [15:0]          blklen;
    logic                 valid_blklen;
    logic signed [BW-1:0] init_branch1;
    logic signed [BW-1:0] init_branch2;
    logic                 valid_branch;
    logic [8*MW-1:0]      alpha_out;
    logic                 valid_alpha;
    logic                 alpha_ready;
    logic                 alpha_last;
    logic [1:0]           fsm_state;
    logic                 ready;
    logic                 len_err;

    siso_alpha_lifo #(.BW(BW), .MW(MW), .MAX_LEN(ML)) dut (
        .clk          (clk),
        .rst          (rst),
        .blklen       (blklen),
        .valid_blklen (valid_blklen),
        .init_branch1 (init_branch1),
        .init_branch2 (init_branch2),
        .valid_branch (valid_branch),
        .alpha_out    (alpha_out),
        .valid_alpha  (valid_alpha),
        .alpha_ready  (alpha_ready),
        .alpha_last   (alpha_last),
        .fsm_state    (fsm_state),
        .ready        (ready),
        .len_err      (len_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        int len;
        int b1;
        int b2;
        int e_s0;
        int e_s4;
    } vec_t;

    vec_t            vecs [3];
    int              n_vec = 0;
    int              n_err = 0;
    int              exp_a [0:ML][0:7];
    logic [8*MW-1:0] first_word;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_word(input string name, input logic [8*MW-1:0] act, input logic [8*MW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic int sat_m(input int v);
        if (v > (1 << (MW - 1)) - 1) return (1 << (MW - 1)) - 1;
        if (v < -(1 << (MW - 1))) return -(1 << (MW - 1));
        return v;
    endfunction

    task automatic model_init();
        exp_a[0][0] = 0;
        for (int s = 1; s < 8; s++) exp_a[0][s] = -(1 << (MW - 1));
    endtask

    // Forward step straight from the trellis equations.
    task automatic model_step(input int k, input int b1, input int b2);
        int nx [8];
        int s1, s2, s3, a, z, ns, g, c, r;
        for (int i = 0; i < 8; i++) nx[i] = -(1 << (MW - 1));
        for (int s = 0; s < 8; s++) begin
            s1 = (s >> 2) & 1;
            s2 = (s >> 1) & 1;
            s3 = s & 1;
            for (int u = 0; u < 2; u++) begin
                a  = u ^ s2 ^ s3;
                z  = a ^ s1 ^ s3;
                ns = a * 4 + s1 * 2 + s2;
                if (u == 1) g = z ? b1 : b2;
                else        g = z ? -b2 : -b1;
                c = sat_m(exp_a[k][s] + g);
                if (c > nx[ns]) nx[ns] = c;
            end
        end
        if (NORM) begin
            r = nx[0];
            for (int i = 0; i < 8; i++) nx[i] = sat_m(nx[i] - r);
        end
        for (int i = 0; i < 8; i++) exp_a[k+1][i] = nx[i];
    endtask

    // Entered and left at a falling edge.
    task automatic start_and_feed(input int n, input int b1, input int b2, input bit rnd);
        int x1, x2;
        blklen       = 16'(n);
        valid_blklen = 1'b1;
        @(negedge clk);
        valid_blklen = 1'b0;
        check("start_fsm_state", int'(fsm_state), 1);
        model_init();
        for (int k = 0; k < n; k++) begin
            x1 = rnd ? int'($urandom_range(0, 255)) - 128 : b1;
            x2 = rnd ? int'($urandom_range(0, 255)) - 128 : b2;
            init_branch1 = 8'(x1);
            init_branch2 = 8'(x2);
            valid_branch = 1'b1;
            model_step(k, x1, x2);
            @(negedge clk);
        end
        // Random frames leave valid_branch asserted through the drain; it must be ignored.
        valid_branch = rnd;
        check("drain_fsm_state", int'(fsm_state), 2);
    endtask

    task automatic drain(input int n, input int stall_at);
        int k = 0, cyc = 0, stall = 0, bubbles = 0, first_cyc = -1;
        logic [8*MW-1:0] held, ev;
        logic held_last;
        alpha_ready = 1'b1;
        while (k < n && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (valid_alpha) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (stall > 0 && stall <= 3 && k == stall_at) begin
                    check_word("hold_alpha_out", alpha_out, held);
                    check("hold_alpha_last", int'(alpha_last), int'(held_last));
                end
                if (k == stall_at && stall < 3) begin
                    alpha_ready = 1'b0;
                    held        = alpha_out;
                    held_last   = alpha_last;
                    stall++;
                end else begin
                    alpha_ready = 1'b1;
                    ev = '0;
                    for (int s = 0; s < 8; s++) ev[s*MW +: MW] = MW'(exp_a[n-1-k][s]);
                    if (k == 0) first_word = alpha_out;
                    check_word($sformatf("word_alpha%0d", n - 1 - k), alpha_out, ev);
                    check($sformatf("last_alpha%0d", n - 1 - k), int'(alpha_last), int'(k == n - 1));
                    k++;
                end
            end else if (first_cyc >= 0) begin
                bubbles++;
            end
        end
        check("drain_word_count", k, n);
        check("first_valid_latency_ok", int'(first_cyc >= 1 && first_cyc <= 2), 1);
        check("drain_bubbles", bubbles, 0);
        @(negedge clk);
        valid_branch = 1'b0;
        check("end_valid_alpha", int'(valid_alpha), 0);
        check("end_ready", int'(ready), 1);
        check("end_fsm_state", int'(fsm_state), 0);
    endtask

    task automatic apply_vec(input vec_t v);
        logic [MW-1:0] f0, f4;
        start_and_feed(v.len, v.b1, v.b2, 1'b0);
        drain(v.len, -1);
        f0 = first_word[0*MW +: MW];
        f4 = first_word[4*MW +: MW];
        check($sformatf("len%0d_first_s0", v.len), int'($signed(f0)), v.e_s0);
        check($sformatf("len%0d_first_s4", v.len), int'($signed(f4)), v.e_s4);
    endtask

    initial begin
        vecs[0] = '{1, 5, 3, 0, -512};
        vecs[1] = '{2, 4, 2, NORM ? 0 : -4, NORM ? 8 : 4};
        vecs[2] = '{2, -6, 1, NORM ? 0 : 6, NORM ? -12 : -6};

        rst          = 1'b1;
        blklen       = '0;
        valid_blklen = 1'b0;
        init_branch1 = '0;
        init_branch2 = '0;
        valid_branch = 1'b0;
        alpha_ready  = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_alpha_out_zero", int'(alpha_out == '0), 1);
        check("rst_valid_alpha", int'(valid_alpha), 0);
        check("rst_alpha_last", int'(alpha_last), 0);
        check("rst_fsm_state", int'(fsm_state), 0);
        check("rst_ready", int'(ready), 1);
        check("rst_len_err", int'(len_err), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 3; i++) apply_vec(vecs[i]);

        // Full-depth frame with random branches and a 3-cycle stall mid-drain.
        start_and_feed(16, 0, 0, 1'b1);
        drain(16, 5);

        // Illegal lengths on both sides of the legal range.
        blklen       = 16'd0;
        valid_blklen = 1'b1;
        @(negedge clk);
        valid_blklen = 1'b0;
        check("len0_len_err", int'(len_err), 1);
        check("len0_fsm_state", int'(fsm_state), 0);
        @(negedge clk);
        check("len0_len_err_drop", int'(len_err), 0);
        blklen       = 16'd17;
        valid_blklen = 1'b1;
        @(negedge clk);
        valid_blklen = 1'b0;
        check("len17_len_err", int'(len_err), 1);
        check("len17_fsm_state", int'(fsm_state), 0);
        @(negedge clk);
        check("len17_len_err_drop", int'(len_err), 0);
        start_and_feed(4, 0, 0, 1'b1);
        drain(4, -1);

        // Reset in the middle of a forward pass.
        blklen       = 16'd8;
        valid_blklen = 1'b1;
        @(negedge clk);
        valid_blklen = 1'b0;
        init_branch1 = 8'sd7;
        init_branch2 = -8'sd3;
        valid_branch = 1'b1;
        repeat (3) @(negedge clk);
        valid_branch = 1'b0;
        check("midfwd_fsm_state", int'(fsm_state), 1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_fsm_state", int'(fsm_state), 0);
        check("midrst_valid_alpha", int'(valid_alpha), 0);
        check("midrst_ready", int'(ready), 1);
        rst = 1'b0;
        @(negedge clk);
        apply_vec(vecs[1]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
